// File: rtl/parity_frame_tx.sv
// parity_frame_tx: serialises one 4-bit nibble per frame onto a single idle-high line.
// Frame, LSB first: start(0), data[0..3], parity (as supplied), stop(1); each bit is held
// for CLKS_PER_BIT cycles. The supplied parity is checked against XOR of data and flagged.
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    synchronous active-low reset
//   data       nibble to send
//   parity     upstream parity for data (expected XOR of data)
//   valid      data/parity valid this cycle
//   ready      block can accept a nibble (IDLE only)
//   tx         registered serial line, idle high
//   busy       frame in progress (~ready)
//   par_err    one-cycle pulse after a handshake with inconsistent parity
//   frame_cnt  completed frames, wraps at 255
module parity_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] data,
  input  logic       parity,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       par_err,
  output logic [7:0] frame_cnt
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [7:0] LastTick = 8'(CLKS_PER_BIT - 1);

  state_e     state_q;
  logic [7:0] tick_q;
  logic [1:0] bit_idx_q;
  logic [3:0] data_q;
  logic       parity_q;
  logic       bit_done;

  assign bit_done = (tick_q == LastTick);
  assign busy     = ~ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      tick_q    <= 8'd0;
      bit_idx_q <= 2'd0;
      data_q    <= 4'd0;
      parity_q  <= 1'b0;
      ready     <= 1'b1;
      tx        <= 1'b1;
      par_err   <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      par_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid) begin
            data_q    <= data;
            parity_q  <= parity;
            par_err   <= parity ^ (^data);
            tx        <= 1'b0;
            tick_q    <= 8'd0;
            bit_idx_q <= 2'd0;
            ready     <= 1'b0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (bit_done) begin
            tick_q  <= 8'd0;
            tx      <= data_q[0];
            state_q <= StData;
          end else begin
            tick_q <= tick_q + 8'd1;
          end
        end
        StData: begin
          if (bit_done) begin
            tick_q <= 8'd0;
            if (bit_idx_q == 2'd3) begin
              tx      <= parity_q;
              state_q <= StParity;
            end else begin
              bit_idx_q <= bit_idx_q + 2'd1;
              tx        <= data_q[bit_idx_q + 2'd1];
            end
          end else begin
            tick_q <= tick_q + 8'd1;
          end
        end
        StParity: begin
          if (bit_done) begin
            tick_q  <= 8'd0;
            tx      <= 1'b1;
            state_q <= StStop;
          end else begin
            tick_q <= tick_q + 8'd1;
          end
        end
        StStop: begin
          // Returning to IDLE guarantees at least one ready cycle between frames.
          if (bit_done) begin
            tick_q    <= 8'd0;
            ready     <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            state_q   <= StIdle;
          end else begin
            tick_q <= tick_q + 8'd1;
          end
        end
        default: begin
          tx      <= 1'b1;
          ready   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] data;
  logic       parity;
  logic       valid;
  logic       sel;  // 0: CLKS_PER_BIT=4 instance, 1: CLKS_PER_BIT=1 instance

  logic       ready4, tx4, busy4, perr4;
  logic [7:0] cnt4;
  logic       ready1, tx1, busy1, perr1;
  logic [7:0] cnt1;

  always #5 clk = ~clk;

  parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .data(data), .parity(parity), .valid(valid && !sel),
    .ready(ready4), .tx(tx4), .busy(busy4), .par_err(perr4), .frame_cnt(cnt4)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .data(data), .parity(parity), .valid(valid && sel),
    .ready(ready1), .tx(tx1), .busy(busy1), .par_err(perr1), .frame_cnt(cnt1)
  );

  // Observed instance
  logic       m_tx, m_ready, m_busy, m_perr;
  logic [7:0] m_cnt;
  int         cpb;
  always_comb begin
    m_tx    = sel ? tx1 : tx4;
    m_ready = sel ? ready1 : ready4;
    m_busy  = sel ? busy1 : busy4;
    m_perr  = sel ? perr1 : perr4;
    m_cnt   = sel ? cnt1 : cnt4;
    cpb     = sel ? 1 : 4;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is {par_err, stop, parity, data, start}; the block is busy
  // for 7*cpb cycles after each accepted nibble.
  logic [7:0] exp_q[$];
  int         m_busy_left = 0;
  logic [7:0] exp_cnt = 8'd0;
  bit         mon_en = 1'b0;
  bit         cap_active = 1'b0;
  bit         post_check = 1'b0;
  int         cap_idx;
  int         bi;
  logic [6:0] obs;
  bit         bad;
  logic [7:0] cur_exp;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("ready", m_ready, m_busy_left == 0);
      chk("busy", m_busy, m_busy_left != 0);
      chk("frame_cnt", m_cnt, exp_cnt);
      if (!reset_n) begin
        cap_active = 1'b0;
        post_check = 1'b0;
        exp_q.delete();
        exp_cnt = 8'd0;
      end else if (cap_active) begin
        bi = cap_idx / cpb;
        if (cap_idx % cpb == 0) obs[bi] = m_tx;
        else if (m_tx !== obs[bi]) bad = 1'b1;
        chk("par_err_quiet", m_perr, 0);
        cap_idx++;
        if (cap_idx == 7 * cpb) begin
          chk("frame_bits", {bad, obs}, {1'b0, cur_exp[6:0]});
          cap_active = 1'b0;
          post_check = 1'b1;
          exp_cnt++;
        end
      end else if (post_check) begin
        chk("idle_gap_tx", m_tx, 1);
        chk("par_err_quiet", m_perr, 0);
        post_check = 1'b0;
      end else if (m_tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got start bit expected idle line at %0t", $time);
          cur_exp = 8'h7f;
        end else begin
          cur_exp = exp_q.pop_front();
          chk("par_err", m_perr, cur_exp[7]);
        end
        obs = 7'd0;
        bad = 1'b0;
        obs[0] = m_tx;
        cap_idx = 1;
        cap_active = 1'b1;
      end else begin
        chk("par_err_quiet", m_perr, 0);
      end
    end
    // Predict the next rising edge.
    if (!reset_n) m_busy_left = 0;
    else if (m_busy_left == 0) begin
      if (valid) begin
        m_busy_left = 7 * cpb;
        exp_q.push_back({parity != (^data), 1'b1, parity, data, 1'b0});
      end
    end else m_busy_left--;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (m_busy_left != 0 && n < 2000) begin tick(); n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL wait_ready: got timeout expected idle within 2000 cycles");
    end
  endtask

  task automatic send(input logic [3:0] d, input logic p);
    wait_ready();
    data = d; parity = p; valid = 1'b1;
    tick();
    valid = 1'b0;
    data = 4'($urandom); parity = 1'($urandom);  // must not disturb the frame in flight
  endtask

  task automatic wait_done();
    int n = 0;
    while ((m_busy_left != 0 || cap_active || post_check) && n < 2000) begin tick(); n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL wait_done: got timeout expected frame end within 2000 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected simulation end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    int         n;
    sel = 1'b0; reset_n = 1'b0; valid = 1'b1; data = 4'hA; parity = 1'b1;
    repeat (3) tick();
    chk("rst_tx4", tx4, 1);       chk("rst_ready4", ready4, 1);
    chk("rst_perr4", perr4, 0);   chk("rst_cnt4", cnt4, 0);
    chk("rst_tx1", tx1, 1);       chk("rst_cnt1", cnt1, 0);
    valid = 1'b0;
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Directed frames, CLKS_PER_BIT=4
    send(4'b1011, 1'b1);
    wait_done();
    chk("cnt_after_first", cnt4, 1);
    send(4'b0011, 1'b1);  // bad parity, still sent as supplied
    wait_done();

    // Valid pulse mid-frame must be ignored
    send(4'h5, 1'b0);
    repeat (10) tick();
    data = 4'hF; parity = 1'b0; valid = 1'b1;
    tick();
    valid = 1'b0;
    wait_done();

    // Reset during the parity bit aborts the frame
    send(4'h6, 1'b0);
    repeat (21) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_tx", tx4, 1);
    chk("abort_cnt", cnt4, 0);
    chk("abort_ready", ready4, 1);
    send(4'h9, 1'b0);
    wait_done();

    // Random frames with occasional bad parity and gaps
    for (int i = 0; i < 8; i++) begin
      d = 4'($urandom);
      send(d, (^d) ^ ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_done();

    // Switch to the CLKS_PER_BIT=1 instance
    reset_n = 1'b0;
    tick();
    sel = 1'b1;
    reset_n = 1'b1;
    send(4'h0, 1'b0);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      d = 4'($urandom);
      send(d, (^d) ^ ($urandom_range(0, 3) == 0));
    end
    wait_done();

    // 256 back-to-back frames with valid held high
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    valid = 1'b1;
    n = 0;
    while (n < 256) begin
      if (m_busy_left == 0) begin
        data = 4'($urandom);
        parity = (^data) ^ ($urandom_range(0, 7) == 0);
        n++;
      end
      tick();
    end
    valid = 1'b0;
    wait_done();
    chk("wrap_cnt", cnt1, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
